dmem_responder: RTL and testbench

- Responder end of the CPU data-memory interface: accepts load/store requests from the core's LSU initiator and returns read data or a write acknowledgement.
- Owns a word-organised data RAM with a configurable wait-state counter.
- Performs byte/halfword lane selection and sign/zero extension on loads, and byte-enable merging on stores.
- Sits between the datapath's ALU address output and the writeback mux.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_lane_align.sv | 85 ++++++++
 rtl/dmem_responder.sv | 191 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the data-memory responder:
//     - size_e  : request size encodings (byte / half / word / reserved)
//     - state_e : responder FSM state encodings
//     - byte_en : byte-enable pattern for a store of a given size and lane
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Byte enables for a store. lo is the already-aligned byte offset within
  // the word. Reserved size enables nothing.
  function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] lo);
    logic [3:0] be;
    unique case (size)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage : dmem_pkg

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
//   Combinational lane handling for the data-memory responder.
//   Loads : extracts the addressed byte/half from the RAM word and sign- or
//           zero-extends it; word loads pass through.
//   Stores: replicates the right-justified store data across all lanes and
//           generates the byte enables.
//   Also flags requests that must not touch the RAM (err).
//
//   Build option MISALIGN_TRAP_EN:
//     defined   - misaligned half/word requests raise err and access nothing.
//     undefined - misaligned low address bits are forced to zero; only the
//                 reserved size raises err.
//
//   Ports
//     size      in   request size
//     addr_lo   in   byte offset within the word (addr[1:0])
//     sext      in   1 = sign-extend loads
//     wdata     in   right-justified store data
//     rword     in   RAM word at the addressed index
//     rdata     out  extended load data (0 when err)
//     wdata_rep out  lane-replicated store data
//     be        out  store byte enables (0 when err)
//     err       out  request must be rejected
// -----------------------------------------------------------------------------
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] rdata,
  output logic [31:0] wdata_rep,
  output logic [3:0]  be,
  output logic        err
);

  logic [1:0]  eff_lo;
  logic [31:0] shifted;

  // NOTE: every output of a combinational block gets a default at the top,
  // so no path through the case statements can leave it unassigned (latch).
  always_comb begin
    eff_lo    = addr_lo;
    err       = (size == SZ_RSVD);
    wdata_rep = wdata;
    rdata     = '0;

`ifdef MISALIGN_TRAP_EN
    if ((size == SZ_HALF && addr_lo[0]) || (size == SZ_WORD && addr_lo != 2'b00)) begin
      err = 1'b1;
    end
`endif

    // Halves only look at addr[1]; words ignore the offset entirely.
    unique case (size)
      SZ_HALF: eff_lo = {addr_lo[1], 1'b0};
      SZ_WORD: eff_lo = 2'b00;
      default: eff_lo = addr_lo;
    endcase

    shifted = rword >> {eff_lo, 3'b000};

    unique case (size)
      SZ_BYTE: begin
        rdata     = {{24{sext & shifted[7]}}, shifted[7:0]};
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        rdata     = {{16{sext & shifted[15]}}, shifted[15:0]};
        wdata_rep = {2{wdata[15:0]}};
      end
      SZ_WORD: rdata = rword;
      default: rdata = '0;
    endcase

    be = err ? 4'b0000 : byte_en(size, eff_lo);
    if (err) begin
      rdata = '0;
    end
  end

endmodule : dmem_lane_align

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Responder end of the CPU data-memory interface. Accepts one load/store at
//   a time, waits WAIT_CYCLES, performs the RAM access on entry into RESP and
//   pulses rsp_valid for one cycle. rsp_rdata/rsp_err hold until the next
//   response. Addresses wrap modulo DEPTH*4.
//
//   Build option MISALIGN_TRAP_EN: see dmem_lane_align.
//
//   Parameters
//     DEPTH        number of 32-bit RAM words (power of two)
//     AW           word-address width, log2(DEPTH)
//     WAIT_CYCLES  wait states between acceptance and response, 0..15
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     req_valid    in   request present
//     req_ready    out  responder idle, can accept
//     req_we       in   1 = store, 0 = load
//     req_addr     in   byte address
//     req_size     in   00 byte, 01 half, 10 word, 11 reserved
//     req_signed   in   loads: 1 = sign-extend
//     req_wdata    in   right-justified store data
//     rsp_valid    out  one-cycle response pulse
//     rsp_rdata    out  extended load data, 0 for stores and errors
//     rsp_err      out  request rejected
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        cap_we, cap_sext;
  logic [AW+1:0] cap_addr;
  size_e       cap_size;
  logic [31:0] cap_wdata;

  logic        acc_we, acc_sext, acc_err, enter_resp, wr_en;
  logic [AW+1:0] acc_addr;
  size_e       acc_size;
  logic [31:0] acc_wdata;

  logic [AW-1:0] word_idx;
  logic [31:0] ram_word, ld_data, st_data;
  logic [3:0]  st_be;

  logic [31:0] mem [DEPTH];

  // Upper address bits are ignored on purpose: the address space wraps.
  logic addr_hi_unused;
  assign addr_hi_unused = ^req_addr[31:AW+2];

  // ---------------------------------------------------------------- FSM ----
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ------------------------------------------------------ request capture --
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_we    <= 1'b0;
      cap_sext  <= 1'b0;
      cap_addr  <= '0;
      cap_size  <= SZ_BYTE;
      cap_wdata <= '0;
    end else if (req_valid && req_ready) begin
      cap_we    <= req_we;
      cap_sext  <= req_signed;
      cap_addr  <= req_addr[AW+1:0];
      cap_size  <= size_e'(req_size);
      cap_wdata <= req_wdata;
    end
  end

  // With zero wait states the access happens on the acceptance edge itself,
  // before the capture registers are loaded, so use the live request then.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we    = req_we;
      acc_sext  = req_signed;
      acc_addr  = req_addr[AW+1:0];
      acc_size  = size_e'(req_size);
      acc_wdata = req_wdata;
    end else begin
      acc_we    = cap_we;
      acc_sext  = cap_sext;
      acc_addr  = cap_addr;
      acc_size  = cap_size;
      acc_wdata = cap_wdata;
    end
  end

  assign word_idx   = acc_addr[AW+1:2];
  assign ram_word   = mem[word_idx];
  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
  // A request interrupted by reset must never reach the array.
  assign wr_en      = enter_resp && acc_we && rst_n;

  dmem_lane_align u_align (
    .size      (acc_size),
    .addr_lo   (acc_addr[1:0]),
    .sext      (acc_sext),
    .wdata     (acc_wdata),
    .rword     (ram_word),
    .rdata     (ld_data),
    .wdata_rep (st_data),
    .be        (st_be),
    .err       (acc_err)
  );

  // ---------------------------------------------------------------- RAM ----
  // NOTE: the data array has no reset; clearing it would need a multi-cycle
  // sequencer and software never relies on its power-up contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------- response ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_rdata <= acc_we ? 32'h0 : ld_data;
      rsp_err   <= acc_err;
    end
  end

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Two responders share one stimulus bus: dut_a (WAIT_CYCLES = 2) and
//   dut_b (WAIT_CYCLES = 0); sel routes req_valid to one of them.
//   The driver pushes the hand-computed expected response for every accepted
//   request; per-DUT monitors pop and compare data, error flag and latency,
//   and check req_ready stays low while a request is outstanding.
//   Latency is counted as acceptance edge to the first rising edge at which
//   rsp_valid is sampled high. Expectations honour MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel, req_valid, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        valid_a, valid_b;
  logic        ready_a, rsp_valid_a, rsp_err_a;
  logic        ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_a, rsp_rdata_b;

  assign valid_a = req_valid & ~sel;
  assign valid_b = req_valid & sel;

  dmem_responder #(.DEPTH(DEPTH), .AW(10), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_ready(ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_signed(req_signed), .req_wdata(req_wdata), .rsp_valid(rsp_valid_a),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
  );

  dmem_responder #(.DEPTH(DEPTH), .AW(10), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_b), .req_ready(ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_signed(req_signed), .req_wdata(req_wdata), .rsp_valid(rsp_valid_b),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t qa[$], qb[$];
  int cyc = 0;
  int n_checks = 0, n_fail = 0;
  int last_a = -100, last_b = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------ monitors --
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (qa.size() > 0) check("a_ready_busy", {31'b0, ready_a}, 32'd0);
      if (rsp_valid_a === 1'b1) begin
        if (qa.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL a_unexpected_rsp actual=rsp_valid_1 required=no_response (cycle %0d)", cyc);
        end else begin
          e = qa.pop_front();
          check("a_rdata", rsp_rdata_a, e.rdata);
          check("a_err", {31'b0, rsp_err_a}, {31'b0, e.err});
          check("a_latency", cyc + 1 - e.acc, 32'd3);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (qb.size() > 0) check("b_ready_busy", {31'b0, ready_b}, 32'd0);
      if (rsp_valid_b === 1'b1) begin
        if (qb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_unexpected_rsp actual=rsp_valid_1 required=no_response (cycle %0d)", cyc);
        end else begin
          e = qb.pop_front();
          check("b_rdata", rsp_rdata_b, e.rdata);
          check("b_err", {31'b0, rsp_err_b}, {31'b0, e.err});
          check("b_latency", cyc + 1 - e.acc, 32'd1);
        end
      end
    end
  end

  // -------------------------------------------------------------- driver --
  // Presents a request and keeps req_valid high until the selected DUT is
  // ready; the request is accepted on the following rising edge. req_valid is
  // left high afterwards so the next call tests that no request is taken
  // before the responder returns to IDLE.
  task automatic issue(input logic s, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic sx, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input logic expect_rsp);
    int   waited = 0;
    bit   got = 0;
    int   acc = 0;
    exp_t e;
    while (!got && waited < 40) begin
      @(negedge clk);
      sel = s; req_valid = 1'b1; req_we = we; req_addr = addr;
      req_size = size; req_signed = sx; req_wdata = wd;
      if ((s ? ready_b : ready_a) === 1'b1) begin
        got = 1;
        acc = cyc + 1;
      end else begin
        waited++;
      end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout actual=never_ready required=ready addr=%h", addr);
    end else begin
      @(posedge clk);
      if (s) begin
        check("b_spacing", {31'b0, (acc - last_b) >= 2}, 32'd1);
        last_b = acc;
      end else begin
        check("a_spacing", {31'b0, (acc - last_a) >= 4}, 32'd1);
        last_a = acc;
      end
      if (expect_rsp) begin
        e.rdata = exp_rd; e.err = exp_err; e.acc = acc;
        if (s) qb.push_back(e); else qa.push_back(e);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b1; req_addr = 32'hFFFF_FFFF;
    req_size = R; req_signed = 1'b1; req_wdata = 32'hA5A5_A5A5;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout actual=%0d/%0d_pending required=0", qa.size(), qb.size());
      qa.delete(); qb.delete();
    end
    @(posedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ready_a"}, {31'b0, ready_a}, 32'd1);
    check({tag, "_valid_a"}, {31'b0, rsp_valid_a}, 32'd0);
    check({tag, "_rdata_a"}, rsp_rdata_a, 32'd0);
    check({tag, "_err_a"}, {31'b0, rsp_err_a}, 32'd0);
    check({tag, "_ready_b"}, {31'b0, ready_b}, 32'd1);
    check({tag, "_valid_b"}, {31'b0, rsp_valid_b}, 32'd0);
    check({tag, "_rdata_b"}, rsp_rdata_b, 32'd0);
    check({tag, "_err_b"}, {31'b0, rsp_err_b}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- main --
  initial begin
    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_size = W; req_signed = 1'b0; req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("rst");
    rst_n = 1'b1;

    // Word store then load.
    issue(0, 1, 32'h10, W, 0, 32'hDEAD_BEEF, 32'h0, 0, 1);
    issue(0, 0, 32'h10, W, 0, 32'h0, 32'hDEAD_BEEF, 0, 1);

    // Byte/half lanes of 0x80FF7F01 at 0x20.
    issue(0, 1, 32'h20, W, 0, 32'h80FF_7F01, 32'h0, 0, 1);
    issue(0, 0, 32'h23, B, 1, 32'h0, 32'hFFFF_FF80, 0, 1);
    issue(0, 0, 32'h23, B, 0, 32'h0, 32'h0000_0080, 0, 1);
    issue(0, 0, 32'h22, H, 1, 32'h0, 32'hFFFF_80FF, 0, 1);
    issue(0, 0, 32'h20, H, 0, 32'h0, 32'h0000_7F01, 0, 1);
    issue(0, 0, 32'h21, B, 1, 32'h0, 32'h0000_007F, 0, 1);
    issue(0, 0, 32'h22, B, 1, 32'h0, 32'hFFFF_FFFF, 0, 1);
    issue(0, 0, 32'h20, H, 1, 32'h0, 32'h0000_7F01, 0, 1);

    // Partial stores (upper store-data bits are junk and must be ignored).
    issue(0, 1, 32'h30, W, 0, 32'h1122_3344, 32'h0, 0, 1);
    issue(0, 1, 32'h31, B, 0, 32'h1234_56AA, 32'h0, 0, 1);
    issue(0, 0, 32'h30, W, 0, 32'h0, 32'h1122_AA44, 0, 1);
    issue(0, 1, 32'h32, H, 0, 32'h5555_BEEF, 32'h0, 0, 1);
    issue(0, 0, 32'h30, W, 0, 32'h0, 32'hBEEF_AA44, 0, 1);

    // Reserved size: error, no RAM access.
    issue(0, 1, 32'h30, R, 0, 32'hFFFF_FFFF, 32'h0, 1, 1);
    issue(0, 0, 32'h30, R, 1, 32'h0, 32'h0, 1, 1);
    issue(0, 0, 32'h30, W, 0, 32'h0, 32'hBEEF_AA44, 0, 1);

    // Misaligned accesses.
    issue(0, 1, 32'h40, W, 0, 32'hCAFE_F00D, 32'h0, 0, 1);
`ifdef MISALIGN_TRAP_EN
    issue(0, 0, 32'h42, W, 0, 32'h0, 32'h0, 1, 1);
    issue(0, 0, 32'h43, H, 0, 32'h0, 32'h0, 1, 1);
`else
    issue(0, 0, 32'h42, W, 0, 32'h0, 32'hCAFE_F00D, 0, 1);
    issue(0, 0, 32'h43, H, 0, 32'h0, 32'h0000_CAFE, 0, 1);
`endif
    idle();
    drain();

    // Reset during WAIT of a store: no response, RAM keeps old value.
    issue(0, 1, 32'h50, W, 0, 32'h0BAD_F00D, 32'h0, 0, 1);
    issue(0, 0, 32'h50, W, 0, 32'h0, 32'h0BAD_F00D, 0, 1);
    idle();
    drain();
    issue(0, 1, 32'h50, W, 0, 32'h1234_5678, 32'h0, 0, 0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    reset_checks("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    issue(0, 0, 32'h50, W, 0, 32'h0, 32'h0BAD_F00D, 0, 1);

    // Address wrap.
    issue(0, 1, DEPTH * 4 + 32'h4, W, 0, 32'h5A5A_A5A5, 32'h0, 0, 1);
    issue(0, 0, 32'h4, W, 0, 32'h0, 32'h5A5A_A5A5, 0, 1);
    idle();
    drain();

    // Zero wait states, requests held back-to-back.
    issue(1, 1, 32'h8, W, 0, 32'h0102_0304, 32'h0, 0, 1);
    issue(1, 0, 32'h8, W, 0, 32'h0, 32'h0102_0304, 0, 1);
    issue(1, 0, 32'h9, B, 0, 32'h0, 32'h0000_0003, 0, 1);
    issue(1, 0, 32'hA, H, 1, 32'h0, 32'h0000_0102, 0, 1);
    issue(1, 1, 32'hB, B, 0, 32'h0000_00F0, 32'h0, 0, 1);
    issue(1, 0, 32'h8, W, 1, 32'h0, 32'hF002_0304, 0, 1);
    issue(1, 0, 32'hB, B, 1, 32'h0, 32'hFFFF_FFF0, 0, 1);
    issue(1, 1, 32'h8, R, 0, 32'h0, 32'h0, 1, 1);
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dmem_responder
